axi4_lite_slave_ram: RTL and testbench

AXI4-Lite slave that fronts a single-port word-addressed RAM. It sits on the system interconnect as a memory or scratch-register target for a CPU or bus master. It accepts one write and one read transaction at a time on independent channels. It applies byte strobes and returns OKAY responses, or SLVERR when range checking is compiled in.

---
 rtl/axi4_lite_slave_ram_pkg.sv | 18 +
 rtl/axi4_lite_ram_bytewe.sv | 30 +++
 rtl/axi4_lite_slave_ram.sv | 184 ++++++++++++++++++
 tb/tb_axi4_lite_slave_ram.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slave_ram_pkg.sv
// Shared types and constants for the AXI4-Lite RAM slave.
// Response encodings and write/read channel state enums.
package axi4_lite_slave_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi4_lite_ram_bytewe.sv
// Single-port-style word RAM with byte write enables.
// One write port, one registered read port; read sees old data on collision.
module axi4_lite_ram_bytewe #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Strobed byte writes; read register loads the pre-write word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4_lite_slave_ram.sv
// AXI4-Lite slave fronting a word-addressed byte-writable RAM.
// Define AXI4_LITE_SLAVE_SLVERR_EN to reject out-of-range addresses with SLVERR.
module axi4_lite_slave_ram
    import axi4_lite_slave_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 2048
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [2:0]              axi_awprot,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    input  logic [2:0]              axi_arprot,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rvalid,
    input  logic                    axi_rready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic                    live;
    w_state_t                w_state;
    logic                    aw_got;
    logic                    w_got;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;

    r_state_t                r_state;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic                    rd_ok;
    logic [DATA_WIDTH-1:0]   ram_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    commit;
    logic                    aw_err;
    logic                    ar_err;
    logic [3:0]              ram_we;

`ifdef AXI4_LITE_SLAVE_SLVERR_EN
    assign aw_err = |aw_addr_q[ADDR_WIDTH-1:IDX_W+2];
    assign ar_err = |axi_araddr[ADDR_WIDTH-1:IDX_W+2];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    assign axi_awready = live && (w_state == W_IDLE) && !aw_got;
    assign axi_wready  = live && (w_state == W_IDLE) && !w_got;
    assign axi_arready = live && (r_state == R_IDLE);

    assign aw_hs  = axi_awvalid && axi_awready;
    assign w_hs   = axi_wvalid && axi_wready;
    assign ar_hs  = axi_arvalid && axi_arready;
    assign commit = (w_state == W_IDLE) && aw_got && w_got;
    assign ram_we = (commit && !aw_err) ? wstrb_q : 4'h0;

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rresp  = rresp_q;
    // Out-of-range reads and idle periods present zero data.
    assign axi_rdata  = rd_ok ? ram_q : '0;

    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot,
                         axi_awaddr[1:0], axi_araddr[1:0],
                         aw_addr_q[1:0],
                         aw_addr_q[ADDR_WIDTH-1:IDX_W+2],
                         axi_araddr[ADDR_WIDTH-1:IDX_W+2]};

    axi4_lite_ram_bytewe #(
        .DEPTH (MEM_DEPTH),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (aw_addr_q[IDX_W+1:2]),
        .wdata (wdata_q),
        .re    (ar_hs),
        .raddr (axi_araddr[IDX_W+1:2]),
        .rdata (ram_q)
    );

    // Out-of-reset flag gating every ready by one edge after release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Write channel: capture AW and W independently, commit, then respond.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got    <= 1'b1;
                        aw_addr_q <= axi_awaddr;
                    end
                    if (w_hs) begin
                        w_got   <= 1'b1;
                        wdata_q <= axi_wdata;
                        wstrb_q <= axi_wstrb;
                    end
                    if (commit) begin
                        aw_got   <= 1'b0;
                        w_got    <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= aw_err ? RESP_SLVERR : RESP_OKAY;
                        w_state  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= RESP_OKAY;
                        w_state  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read channel: RAM word registered on AR, held until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rd_ok    <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rd_ok    <= !ar_err;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_rready) begin
                        rvalid_q <= 1'b0;
                        rresp_q  <= RESP_OKAY;
                        rd_ok    <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_ram.sv
// Directed self-checking bench for axi4_lite_slave_ram.
// Expected values are hand-computed constants per scenario.
module tb_axi4_lite_slave_ram;

    logic        aclk;
    logic        aresetn;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    int total = 0;
    int bad   = 0;

    axi4_lite_slave_ram dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awprot  (axi_awprot),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_arprot  (axi_arprot),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold,
                            output logic [1:0] resp);
        logic a;
        logic w;
        logic a_done;
        logic w_done;
        int   n;
        axi_awaddr  = addr;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_bready  = 1'b0;
        a_done = 1'b0;
        w_done = 1'b0;
        n = 0;
        while (!(a_done && w_done) && n < 20) begin
            @(negedge aclk);
            a = axi_awvalid && axi_awready;
            w = axi_wvalid && axi_wready;
            @(posedge aclk); #1;
            if (a) begin axi_awvalid = 1'b0; a_done = 1'b1; end
            if (w) begin axi_wvalid = 1'b0; w_done = 1'b1; end
            n++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        if (n >= 20) chk("wr_hs_timeout", 0, 1);
        n = 0;
        while (n < 20) begin
            @(negedge aclk);
            if (axi_bvalid) break;
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 20) chk("b_timeout", 0, 1);
        else chk("b_latency", n, 1);
        resp = axi_bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            chk("b_hold_valid", axi_bvalid, 1);
            chk("b_hold_resp", axi_bresp, resp);
            chk("b_hold_awrdy", axi_awready, 0);
        end
        @(posedge aclk); #1;
        axi_bready = 1'b1;
        @(posedge aclk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        logic a;
        logic a_done;
        int   n;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        axi_rready  = 1'b0;
        a_done = 1'b0;
        n = 0;
        while (!a_done && n < 20) begin
            @(negedge aclk);
            a = axi_arvalid && axi_arready;
            @(posedge aclk); #1;
            if (a) begin axi_arvalid = 1'b0; a_done = 1'b1; end
            n++;
        end
        axi_arvalid = 1'b0;
        if (n >= 20) chk("ar_timeout", 0, 1);
        n = 0;
        while (n < 20) begin
            @(negedge aclk);
            if (axi_rvalid) break;
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 20) chk("r_timeout", 0, 1);
        else chk("r_latency", n, 0);
        data = axi_rdata;
        resp = axi_rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            chk("r_hold_valid", axi_rvalid, 1);
            chk("r_hold_data", axi_rdata, data);
            chk("r_hold_resp", axi_rresp, resp);
            chk("r_hold_arrdy", axi_arready, 0);
        end
        @(posedge aclk); #1;
        axi_rready = 1'b1;
        @(posedge aclk); #1;
        axi_rready = 1'b0;
    endtask

    logic [1:0]  br;
    logic [1:0]  rr;
    logic [31:0] rd;
    int          aw_n;
    int          w_n;

    initial begin
        aresetn     = 1'b0;
        axi_awaddr  = '0;
        axi_awvalid = 1'b0;
        axi_awprot  = 3'b0;
        axi_wdata   = '0;
        axi_wstrb   = 4'h0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_araddr  = '0;
        axi_arvalid = 1'b0;
        axi_arprot  = 3'b0;
        axi_rready  = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awrdy", axi_awready, 0);
        chk("rst_wrdy", axi_wready, 0);
        chk("rst_arrdy", axi_arready, 0);
        chk("rst_bvalid", axi_bvalid, 0);
        chk("rst_rvalid", axi_rvalid, 0);
        chk("rst_bresp", axi_bresp, 0);
        chk("rst_rresp", axi_rresp, 0);
        chk("rst_rdata", axi_rdata, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_awrdy_low", axi_awready, 0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rel_awrdy", axi_awready, 1);
        chk("rel_wrdy", axi_wready, 1);
        chk("rel_arrdy", axi_arready, 1);
        @(posedge aclk); #1;

        // Basic full-word write and read back.
        do_write(32'h1000, 32'h12345678, 4'hF, 0, br);
        chk("wr1_bresp", br, 2'b00);
        do_read(32'h1000, 0, rd, rr);
        chk("rd1_data", rd, 32'h12345678);
        chk("rd1_rresp", rr, 2'b00);

        // W presented before AW; valids held past their handshakes.
        axi_wdata  = 32'hDEADBEEF;
        axi_wstrb  = 4'hF;
        axi_awaddr = 32'h0004;
        axi_wvalid = 1'b1;
        aw_n = 0;
        w_n  = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            if (axi_wvalid && axi_wready) w_n++;
            if (axi_awvalid && axi_awready) aw_n++;
            if (c == 2) chk("ooo_bv_early", axi_bvalid, 0);
            if (c == 3) chk("ooo_bv", axi_bvalid, 1);
            @(posedge aclk); #1;
            if (c == 0) axi_awvalid = 1'b1;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        chk("ooo_w_pulses", w_n, 1);
        chk("ooo_aw_pulses", aw_n, 1);
        axi_bready = 1'b1;
        @(posedge aclk); #1;
        axi_bready = 1'b0;
        do_read(32'h0004, 0, rd, rr);
        chk("ooo_rdata", rd, 32'hDEADBEEF);

        // Byte strobes.
        do_write(32'h0008, 32'hFFFFFFFF, 4'hF, 0, br);
        do_write(32'h0008, 32'h000000AA, 4'b0001, 0, br);
        do_read(32'h0008, 0, rd, rr);
        chk("strb_lo", rd, 32'hFFFFFFAA);
        do_write(32'h1002, 32'h11223344, 4'b1010, 0, br);
        do_read(32'h1000, 0, rd, rr);
        chk("strb_mix", rd, 32'h11343378);

        // Response backpressure on both channels.
        do_write(32'h000C, 32'hA5A5A5A5, 4'hF, 5, br);
        chk("bp_bresp", br, 2'b00);
        do_read(32'h000C, 5, rd, rr);
        chk("bp_rdata", rd, 32'hA5A5A5A5);

        // Reset while the write response is pending.
        axi_awaddr  = 32'h0010;
        axi_wdata   = 32'h01020304;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        @(posedge aclk); #1;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("mid_bvalid", axi_bvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_bvalid", axi_bvalid, 0);
        chk("mid_rst_awrdy", axi_awready, 0);
        chk("mid_rst_arrdy", axi_arready, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_rel_awrdy_low", axi_awready, 0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("mid_rel_awrdy", axi_awready, 1);
        chk("mid_rel_arrdy", axi_arready, 1);
        @(posedge aclk); #1;
        do_read(32'h0010, 0, rd, rr);
        chk("mid_committed", rd, 32'h01020304);

        // Out-of-range address: SLVERR or aliasing onto word 0.
        do_write(32'h0000, 32'h0BADC0DE, 4'hF, 0, br);
        do_write(32'h4000, 32'h55AA55AA, 4'hF, 0, br);
`ifdef AXI4_LITE_SLAVE_SLVERR_EN
        chk("oor_bresp", br, 2'b10);
        do_read(32'h4000, 0, rd, rr);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_rresp", rr, 2'b10);
        do_read(32'h0000, 0, rd, rr);
        chk("oor_word0", rd, 32'h0BADC0DE);
        chk("oor_word0_resp", rr, 2'b00);
`else
        chk("alias_bresp", br, 2'b00);
        do_read(32'h4000, 0, rd, rr);
        chk("alias_rdata", rd, 32'h55AA55AA);
        chk("alias_rresp", rr, 2'b00);
        do_read(32'h0000, 0, rd, rr);
        chk("alias_word0", rd, 32'h55AA55AA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
